// File: rtl/digit_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : digit_scanner_if
// Purpose  : Control and display-select bundle between score logic and scanner.
// Revision : 1.0
// ============================================================================
interface digit_scanner_if;
    logic       en;
    logic [3:0] dig_en;
    logic [3:0] blink_en;
    logic [3:0] sel;
    logic [1:0] digit_idx;
    logic [3:0] an;
    logic       digit_tick;

    modport master (
        output en, dig_en, blink_en,
        input  sel, digit_idx, an, digit_tick
    );

    modport slave (
        input  en, dig_en, blink_en,
        output sel, digit_idx, an, digit_tick
    );
endinterface
`default_nettype wire

// File: rtl/digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : digit_scanner
// Purpose  : 4-digit 7-seg scan: one-hot select, anode dead-time, enable/blink masks.
// Revision : 1.0
// ============================================================================
module digit_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_BITS   = 25
) (
    input  wire logic        clk,
    input  wire logic        rst,
    digit_scanner_if.slave   scan
);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [PW-1:0] c_presc_last = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] c_bcnt_last  = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam state_t        c_tick_state = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

    logic [PW-1:0]         presc_q, presc_d;
    logic [3:0]            sel_q, sel_d;
    logic [1:0]            idx_q, idx_d;
    state_t                state_q, state_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic [BLINK_BITS-1:0] blink_q, blink_d;
    logic                  w_tick;
    logic                  w_blink_phase;

    assign w_tick        = scan.en && (presc_q == c_presc_last);
    assign w_blink_phase = blink_q[BLINK_BITS-1];

    always_comb begin
        presc_d = presc_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        state_d = state_q;
        bcnt_d  = bcnt_q;
        blink_d = blink_q + 1'b1;
        if (w_tick) begin
            presc_d = '0;
            bcnt_d  = '0;
            state_d = c_tick_state;
            // A corrupted select recovers to digit 0 rather than propagating.
            if ($onehot(sel_q)) begin
                sel_d = {sel_q[2:0], sel_q[3]};
                idx_d = idx_q + 2'd1;
            end else begin
                sel_d = 4'b0001;
                idx_d = 2'd0;
            end
        end else if (scan.en) begin
            presc_d = presc_q + 1'b1;
            if (state_q == ST_BLANK) begin
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_q == c_bcnt_last) begin
                    state_d = ST_DRIVE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            sel_q   <= 4'b0001;
            idx_q   <= 2'd0;
            state_q <= ST_BLANK;
            bcnt_q  <= '0;
            blink_q <= '0;
        end else begin
            presc_q <= presc_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
        end
    end

    // Anodes depend only on registered state and static masks, never on presc.
    assign scan.an = ((state_q == ST_DRIVE) && scan.en)
                   ? ~(sel_q & scan.dig_en & ~({4{w_blink_phase}} & scan.blink_en))
                   : 4'b1111;

    assign scan.sel        = sel_q;
    assign scan.digit_idx  = idx_q;
    assign scan.digit_tick = w_tick;

endmodule
`default_nettype wire
